calc_key_entry: RTL and testbench

- Sits directly downstream of the keypad scanner. Consumes its 4-bit keycode and keypressed strobe and turns key events into calculator operands and an operator.
- Issues a valid/ready execute request to the ALU and holds the value to be shown on the display.
- Digit entry is decimal; operands are held in binary.

---
 rtl/calc_key_entry.sv | 242 ++++++++++++++++++++++++
 tb/tb_calc_key_entry.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_entry.sv
`default_nettype none
// ============================================================================
// calc_key_entry : keypad events -> decimal operands, operator, ALU request.
// Optional CALC_KEY_ENTRY_FIFO_EN buffers keys typed during EXEC. Rev 1.0
// ============================================================================
module calc_key_entry #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [3:0]       keycode,
  input  logic             keypressed,
  input  logic             exec_ready,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [1:0]       op,
  output logic             exec_valid,
  output logic [WIDTH-1:0] display_value,
  output logic             key_dropped
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_ENTER_A = 3'd0,
    S_OP_WAIT = 3'd1,
    S_ENTER_B = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_t;

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_a, w_a, r_b, w_b, r_disp, w_disp;
  logic [CW-1:0]    r_cnt_a, w_cnt_a, r_cnt_b, w_cnt_b;
  logic [1:0]       r_op, w_op;
  logic             r_valid, w_valid, r_drop, w_drop;

  logic             r_kp_q;
  logic             w_event;
  logic             w_key_vld;
  logic [3:0]       w_key;
  logic             w_evt_drop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_kp_q <= 1'b0;
    else          r_kp_q <= keypressed;
  end

  assign w_event = keypressed & ~r_kp_q;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
  end

`ifdef CALC_KEY_ENTRY_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_fcnt;
  logic          w_push, w_pop;

  // Keys wait in the FIFO while the ALU request is outstanding.
  assign w_pop      = (r_fcnt != '0) && (r_state != S_EXEC);
  assign w_push     = w_event && (r_fcnt != (AW+1)'(FIFO_DEPTH));
  assign w_evt_drop = w_event && !w_push;
  assign w_key_vld  = w_pop;
  assign w_key      = r_mem[r_rd];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= keycode;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_fcnt <= r_fcnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
`else
  assign w_key_vld  = w_event;
  assign w_key      = keycode;
  assign w_evt_drop = w_event && (r_state == S_EXEC);
`endif

  logic             w_is_digit, w_is_op, w_is_clr, w_is_eq, w_is_bs;
  logic [1:0]       w_op_code;
  logic [WIDTH-1:0] w_digit;

  assign w_is_digit = w_key_vld && (w_key <= 4'h9);
  assign w_is_op    = w_key_vld && ((w_key == 4'hA) || (w_key == 4'hB) || (w_key == 4'hC));
  assign w_is_clr   = w_key_vld && (w_key == 4'hD);
  assign w_is_eq    = w_key_vld && (w_key == 4'hE);
  assign w_is_bs    = w_key_vld && (w_key == 4'hF);
  // 0xA/0xB/0xC map to 0/1/2 by adding 2 to the low bits.
  assign w_op_code  = w_key[1:0] + 2'd2;
  assign w_digit    = WIDTH'(w_key);

  function automatic logic [WIDTH-1:0] f_append(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] d);
    return (v << 3) + (v << 1) + d;
  endfunction

  function automatic logic [WIDTH-1:0] f_drop_digit(input logic [WIDTH-1:0] v);
    return v / WIDTH'(10);
  endfunction

  always_comb begin
    w_state = r_state;
    w_a     = r_a;
    w_b     = r_b;
    w_cnt_a = r_cnt_a;
    w_cnt_b = r_cnt_b;
    w_op    = r_op;
    w_valid = r_valid;
    w_disp  = r_disp;
    w_drop  = w_evt_drop;

    case (r_state)
      S_ENTER_A: begin
        if (w_is_digit && (r_cnt_a < CW'(MAX_DIGITS))) begin
          w_a     = f_append(r_a, w_digit);
          w_cnt_a = r_cnt_a + CW'(1);
          w_disp  = w_a;
        end else if (w_is_bs && (r_cnt_a != '0)) begin
          w_a     = f_drop_digit(r_a);
          w_cnt_a = r_cnt_a - CW'(1);
          w_disp  = w_a;
        end else if (w_is_op) begin
          w_op    = w_op_code;
          w_state = S_OP_WAIT;
        end
      end
      S_OP_WAIT: begin
        if (w_is_digit) begin
          w_b     = w_digit;
          w_cnt_b = CW'(1);
          w_disp  = w_digit;
          w_state = S_ENTER_B;
        end else if (w_is_op) begin
          w_op = w_op_code;
        end else if (w_is_bs) begin
          w_disp  = r_a;
          w_state = S_ENTER_A;
        end
      end
      S_ENTER_B: begin
        if (w_is_digit && (r_cnt_b < CW'(MAX_DIGITS))) begin
          w_b     = f_append(r_b, w_digit);
          w_cnt_b = r_cnt_b + CW'(1);
          w_disp  = w_b;
        end else if (w_is_bs && (r_cnt_b != '0)) begin
          w_b     = f_drop_digit(r_b);
          w_cnt_b = r_cnt_b - CW'(1);
          w_disp  = w_b;
        end else if (w_is_eq) begin
          w_valid = 1'b1;
          w_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_valid && exec_ready) begin
          w_a     = result;
          w_disp  = result;
          // A result has no typed-digit history; treat it as a full operand.
          w_cnt_a = CW'(MAX_DIGITS);
          w_valid = 1'b0;
          w_state = S_SHOW;
        end
      end
      S_SHOW: begin
        if (w_is_digit) begin
          w_a     = w_digit;
          w_cnt_a = CW'(1);
          w_disp  = w_digit;
          w_state = S_ENTER_A;
        end else if (w_is_op) begin
          w_op    = w_op_code;
          w_state = S_OP_WAIT;
        end else if (w_is_eq) begin
          w_valid = 1'b1;
          w_state = S_EXEC;
        end
      end
      default: begin
        w_state = S_ENTER_A;
        w_valid = 1'b0;
      end
    endcase

    if (w_is_clr && (r_state != S_EXEC)) begin
      w_state = S_ENTER_A;
      w_a     = '0;
      w_b     = '0;
      w_cnt_a = '0;
      w_cnt_b = '0;
      w_op    = 2'd0;
      w_valid = 1'b0;
      w_disp  = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_op    <= 2'd0;
      r_valid <= 1'b0;
      r_disp  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_a     <= w_a;
      r_b     <= w_b;
      r_cnt_a <= w_cnt_a;
      r_cnt_b <= w_cnt_b;
      r_op    <= w_op;
      r_valid <= w_valid;
      r_disp  <= w_disp;
      r_drop  <= w_drop;
    end
  end

  assign operand_a     = r_a;
  assign operand_b     = r_b;
  assign op            = r_op;
  assign exec_valid    = r_valid;
  assign display_value = r_disp;
  assign key_dropped   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_calc_key_entry.sv
`default_nettype none
// Directed bench for calc_key_entry; hand-computed expectations.
module tb_calc_key_entry;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  keycode = 4'h0;
  logic        keypressed = 1'b0;
  logic        exec_ready = 1'b0;
  logic [15:0] result = 16'd0;
  logic [15:0] operand_a, operand_b, display_value;
  logic [1:0]  op;
  logic        exec_valid, key_dropped;

  int checks = 0;
  int failures = 0;
  int drop_cnt = 0;
  int base;
  int vcnt;

  calc_key_entry dut (
    .clock(clock), .reset_n(reset_n), .keycode(keycode), .keypressed(keypressed),
    .exec_ready(exec_ready), .result(result), .operand_a(operand_a),
    .operand_b(operand_b), .op(op), .exec_valid(exec_valid),
    .display_value(display_value), .key_dropped(key_dropped)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (key_dropped === 1'b1) drop_cnt <= drop_cnt + 1;

  initial begin
    #2ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clock);
    keycode = k;
    keypressed = 1'b1;
    @(negedge clock);
    keypressed = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_exec(input logic [15:0] res);
    for (int i = 0; i < 20 && exec_valid !== 1'b1; i++) @(negedge clock);
    chk("exec_req", exec_valid, 1);
    exec_ready = 1'b1;
    result = res;
    @(negedge clock);
    exec_ready = 1'b0;
    chk("exec_done_valid", exec_valid, 0);
    chk("exec_done_disp", display_value, res);
    chk("exec_done_a", operand_a, res);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clock);
    chk("rst_a", operand_a, 0);
    chk("rst_b", operand_b, 0);
    chk("rst_op", op, 0);
    chk("rst_valid", exec_valid, 0);
    chk("rst_disp", display_value, 0);
    chk("rst_drop", key_dropped, 0);
    reset_n = 1'b1;

    // Held strobe gives one digit
    @(negedge clock);
    keycode = 4'h7;
    keypressed = 1'b1;
    repeat (50) @(negedge clock);
    keypressed = 1'b0;
    @(negedge clock);
    chk("hold_a", operand_a, 7);
    chk("hold_disp", display_value, 7);
    press(4'hD);
    chk("clear_a", operand_a, 0);

    // Digit limit and backspace
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk("five_digits", operand_a, 1234);
    press(4'hF);
    chk("bs_123", operand_a, 123);
    press(4'hF); press(4'hF); press(4'hF);
    chk("bs_zero", operand_a, 0);
    press(4'hF);
    chk("bs_at_zero", operand_a, 0);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h9);
    chk("count_restart", operand_a, 5678);
    chk("count_restart_disp", display_value, 5678);
    press(4'hD);

    // 12 + 3 with a 5-cycle ALU stall; stray ready before the request
    exec_ready = 1'b1;
    press(4'h1); press(4'h2); press(4'hA); press(4'h3);
    chk("ready_ignored_valid", exec_valid, 0);
    chk("ready_ignored_a", operand_a, 12);
    chk("enter_b_disp", display_value, 3);
    exec_ready = 1'b0;
    @(negedge clock);
    keycode = 4'hE;
    keypressed = 1'b1;
    @(negedge clock);
    keypressed = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (exec_valid === 1'b1) vcnt++;
      chk("stall_a", operand_a, 12);
      chk("stall_b", operand_b, 3);
      chk("stall_op", op, 0);
      @(negedge clock);
    end
    if (exec_valid === 1'b1) vcnt++;
    exec_ready = 1'b1;
    result = 16'd15;
    @(negedge clock);
    exec_ready = 1'b0;
    chk("valid_cycles", vcnt, 6);
    chk("res15_valid", exec_valid, 0);
    chk("res15_disp", display_value, 15);
    chk("res15_a", operand_a, 15);

    // Repeat equals, then subtract
    press(4'hE);
    chk("repeat_valid", exec_valid, 1);
    chk("repeat_a", operand_a, 15);
    chk("repeat_b", operand_b, 3);
    do_exec(16'd18);
    press(4'hB);
    press(4'h5);
    chk("sub_b_disp", display_value, 5);
    press(4'hE);
    chk("sub_op", op, 1);
    chk("sub_a", operand_a, 18);
    chk("sub_b", operand_b, 5);
    do_exec(16'd13);

    // Keys during EXEC: 9 then 1,2,3,4
    press(4'hE);
    base = drop_cnt;
    @(negedge clock);
    keycode = 4'h9;
    keypressed = 1'b1;
    @(negedge clock);
`ifdef CALC_KEY_ENTRY_FIFO_EN
    chk("exec_key_drop", key_dropped, 0);
`else
    chk("exec_key_drop", key_dropped, 1);
`endif
    keypressed = 1'b0;
    @(negedge clock);
    chk("exec_key_drop_end", key_dropped, 0);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("exec_hold_a", operand_a, 13);
    chk("exec_hold_b", operand_b, 5);
    chk("exec_hold_op", op, 1);
`ifdef CALC_KEY_ENTRY_FIFO_EN
    chk("drop_count", drop_cnt - base, 1);
`else
    chk("drop_count", drop_cnt - base, 5);
`endif
    do_exec(16'd8);
    @(negedge clock);
`ifdef CALC_KEY_ENTRY_FIFO_EN
    chk("after_exec_a", operand_a, 9);
`else
    chk("after_exec_a", operand_a, 8);
`endif
    repeat (3) @(negedge clock);
`ifdef CALC_KEY_ENTRY_FIFO_EN
    chk("queued_keys_a", operand_a, 9123);
`else
    chk("queued_keys_a", operand_a, 8);
`endif

    // Asynchronous reset during EXEC
    press(4'hD);
    press(4'h2); press(4'hA); press(4'h3); press(4'hE);
    chk("pre_reset_valid", exec_valid, 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", exec_valid, 0);
    chk("async_a", operand_a, 0);
    chk("async_b", operand_b, 0);
    chk("async_disp", display_value, 0);
    @(negedge clock);
    reset_n = 1'b1;
    press(4'h4); press(4'h5);
    chk("post_reset_a", operand_a, 45);
    chk("post_reset_b", operand_b, 0);
    press(4'hE);
    chk("post_reset_eq_ignored", exec_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
